// File: rtl/arb_hs_sink.sv
// ---------------------------------------------------------------------------
// arb_hs_sink
//
// Synchronous consumer for the 2-input asynchronous arbiter. It closes the
// arbiter's 4-phase req/ack handshake in the clk domain, records the
// arbiter's select bit for every grant, and queues the grants in a small
// first-word-fall-through FIFO that is read through a valid/ready stream.
// While the FIFO is full the acknowledge is withheld, which stalls the
// arbiter until space frees up.
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   rst         synchronous reset, active-high
//   req_in      asynchronous request from the arbiter
//   sel_in      arbiter select bit, bundled with req_in (stable while high)
//   ack_out     registered acknowledge back to the arbiter
//   out_valid   FIFO head holds a grant
//   out_ready   consumer accepts the head entry
//   out_sel     channel index at the FIFO head (0 when empty)
//   fifo_level  number of queued grants, 0..FIFO_DEPTH
//   grant_cnt0  grants pushed for channel 0 (only with GRANT_CNT_EN)
//   grant_cnt1  grants pushed for channel 1 (only with GRANT_CNT_EN)
//
// Build option:
//   GRANT_CNT_EN  when defined, adds the per-channel grant counters and
//                 their output ports. Without it the block is otherwise
//                 identical.
// ---------------------------------------------------------------------------
module arb_hs_sink #(
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_in,
   input  logic                          sel_in,
   output logic                          ack_out,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_sel,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef GRANT_CNT_EN
   ,output logic [CNT_W-1:0]             grant_cnt0
   ,output logic [CNT_W-1:0]             grant_cnt1
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] ACK     = 2'd2;

   logic [SYNC_STAGES-1:0] reqSync_q;
   logic                   reqS;

   logic [1:0]             state_q;
   logic [1:0]             state_d;
   logic                   ack_q;

   logic                   mem_q [FIFO_DEPTH];
   logic [PW-1:0]          wrPtr_q;
   logic [PW-1:0]          rdPtr_q;
   logic [LW-1:0]          level_q;

   logic                   push;
   logic                   pop;
   logic                   fifoFull;

   // The arbiter's request is asynchronous to clk, so it goes through a
   // plain flop chain before the FSM looks at it. sel_in skips this chain
   // on purpose: it is guaranteed stable for as long as req_in is high,
   // and by the time the synchronized request reaches the FSM it is
   // long settled.
   always_ff @(posedge clk) begin
      if (rst) begin
         reqSync_q <= '0;
      end else begin
         reqSync_q <= {reqSync_q[SYNC_STAGES-2:0], req_in};
      end
   end

   assign reqS = reqSync_q[SYNC_STAGES-1];

   // Fullness is judged on the level at the start of the cycle, so a pop
   // in the same cycle cannot make room for a push until the next edge.
   assign fifoFull  = (level_q == LW'(FIFO_DEPTH));
   assign out_valid = (level_q != '0);
   assign pop       = out_valid && out_ready;

   // Handshake FSM. CAPTURE is the only state that pushes, and it leaves
   // as soon as it has pushed, so each 4-phase cycle enqueues exactly one
   // grant. If the FIFO is full it simply parks in CAPTURE, which keeps
   // ack low and holds the arbiter off.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (reqS) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (!fifoFull) begin
               push    = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            if (!reqS) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ack is registered off the next state so that it changes in the same
   // cycle the FSM enters or leaves ACK, with no combinational path from
   // the FSM decode to the arbiter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= (state_d == ACK);
      end
   end

   assign ack_out = ack_q;

   // Storage array for the grant FIFO. The entries need no reset because
   // nothing reads them unless the level says they hold data.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= sel_in;
      end
   end

   // Pointer and occupancy bookkeeping. Depth is a power of two, so the
   // pointers wrap naturally; the level carries one extra bit so it can
   // represent a completely full FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + PW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   assign out_sel    = out_valid ? mem_q[rdPtr_q] : 1'b0;
   assign fifo_level = level_q;

`ifdef GRANT_CNT_EN
   logic [CNT_W-1:0] grantCnt0_q;
   logic [CNT_W-1:0] grantCnt1_q;

   // Per-channel grant statistics, bumped on every push and allowed to
   // wrap freely.
   always_ff @(posedge clk) begin
      if (rst) begin
         grantCnt0_q <= '0;
         grantCnt1_q <= '0;
      end else if (push) begin
         if (sel_in) begin
            grantCnt1_q <= grantCnt1_q + CNT_W'(1);
         end else begin
            grantCnt0_q <= grantCnt0_q + CNT_W'(1);
         end
      end
   end

   assign grant_cnt0 = grantCnt0_q;
   assign grant_cnt1 = grantCnt1_q;
`endif

endmodule

// File: doc/arb_hs_sink.md
Name: arb_hs_sink

Overview:
- Synchronous consumer placed directly downstream of the 2-input asynchronous arbiter.
- Terminates the arbiter's 4-phase output handshake (req/ack) in the `clk` domain and captures the arbiter's select bit for each grant.
- Queues each grant as a 1-bit channel index in a small FIFO, exposed on a valid/ready stream to synchronous logic.
- Back-pressures the arbiter by withholding ack while the FIFO is full.

Parameters:
- SYNC_STAGES, 2, number of flops in the req_in synchronizer; legal range 2..4.
- FIFO_DEPTH, 4, grant FIFO entries; power of 2, at least 2.
- CNT_W, 16, width of per-channel grant counters; used only with the optional feature.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- req_in  input  1  asynchronous request from the arbiter's req_out.
- sel_in  input  1  arbiter select bit (0 = channel 0, 1 = channel 1); bundled data, stable while req_in is high.
- ack_out  output  1  acknowledge to the arbiter's ack_out input; registered.
- out_valid  output  1  FIFO head holds a grant.
- out_ready  input  1  consumer accepts the head entry.
- out_sel  output  1  channel index at the FIFO head.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued entries.
- grant_cnt0  output  CNT_W  grants recorded for channel 0; only with GRANT_CNT_EN.
- grant_cnt1  output  CNT_W  grants recorded for channel 1; only with GRANT_CNT_EN.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Synchronizer flops cleared; FSM enters IDLE.
  - ack_out=0, FIFO emptied, out_valid=0, out_sel=0, fifo_level=0, counters=0.
  - Reset has priority over all other activity.
- Synchronizer: req_in passes through SYNC_STAGES flops; req_s is the last stage. sel_in is not synchronized; it is sampled directly in CAPTURE, which is legal under the bundled-data guarantee.
- FSM, with ack_out registered as (next_state == ACK):
  - IDLE: req_s=1 -> CAPTURE.
  - CAPTURE:
    - FIFO not full (evaluated on the current-cycle level, before any pop) -> push sel_in, go to ACK.
    - FIFO full -> remain in CAPTURE with ack_out=0. This stalls the arbiter.
  - ACK: ack_out=1; req_s=0 -> IDLE (ack_out=0 from the next cycle).
- Handshake latency:
  - ack_out rises 1 cycle after the edge where req_s is first seen high with space available (IDLE->CAPTURE->ACK).
  - Exactly one FIFO push occurs per 4-phase cycle.
  - ack_out falls 1 cycle after req_s is seen low.
- A new request is not recognized until the FSM has returned to IDLE with ack_out=0 and req_s has gone high again.
- FIFO:
  - Synchronous, first-word-fall-through; out_sel is valid whenever out_valid=1.
  - Pop occurs when out_valid && out_ready.
  - Push to a full FIFO never occurs.
  - Simultaneous push and pop with 0 < level < DEPTH keeps the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level tracks the occupancy exactly from 0 to FIFO_DEPTH.
- Reset mid-handshake:
  - ack_out drops immediately after the reset edge.
  - If req_in is still high after reset, it is treated as a fresh request: captured, pushed and acknowledged again.

Optional Feature:
- GRANT_CNT_EN defined:
  - grant_cnt0 and grant_cnt1 are present.
  - On each FIFO push, the counter selected by sel_in increments by 1, wrapping modulo 2^CNT_W.
  - Counters clear on rst.
- GRANT_CNT_EN undefined: the ports and counters are removed; all other behaviour is identical.

Test Plan:
- Reset then single request:
  - Stimulus: rst for 2 cycles; raise req_in with sel_in=1; hold out_ready=0.
  - Required: ack_out rises SYNC_STAGES+2 cycles after req_in; out_valid=1, out_sel=1, fifo_level=1.
  - Then drop req_in: ack_out falls SYNC_STAGES+1 cycles later.
- Alternating grants:
  - Stimulus: four full handshakes with sel_in = 0,1,1,0 and out_ready=1.
  - Required: out_sel stream is 0,1,1,0; fifo_level never exceeds 1; with GRANT_CNT_EN, grant_cnt0=2 and grant_cnt1=2.
- Full back-pressure:
  - Stimulus: FIFO_DEPTH=4 and out_ready=0; complete 4 handshakes, then raise a 5th req.
  - Required: ack_out stays 0, FSM remains in CAPTURE, fifo_level=4.
  - Then pulse out_ready for 1 cycle: ack_out rises 2 cycles later and fifo_level returns to 4.
- Simultaneous push and pop:
  - Stimulus: level=2 and out_ready=1 in the same cycle as a CAPTURE push.
  - Required: level stays 2; FIFO order is preserved across the pointer wrap.
- Reset mid-operation:
  - Stimulus: assert rst while in ACK with req_in still high.
  - Required: next cycle ack_out=0 and fifo_level=0; after rst is released, the request is re-captured and ack_out rises again with fifo_level=1.
- Counter wrap (GRANT_CNT_EN, CNT_W=2):
  - Stimulus: five channel-1 grants.
  - Required: grant_cnt1=1 and grant_cnt0=0.
